// File: rtl/food_flush_if.sv
// Bus between the food-flush controller and its surroundings: pacman position,
// level init, the food_map RAM port and the eat/status outputs.
interface food_flush_if #(
  parameter int MAP_COLS = 40,
  parameter int MAP_ROWS = 30,
  parameter int CNT_W    = 12
);
  // pos_valid is a one-cycle qualifier with no ready: the controller always takes
  // the position, either directly or into a single latest-wins pending slot.
  logic                        pos_valid;
  logic [10:0]                 pacman_curr_pos_x;
  logic [9:0]                  pacman_curr_pos_y;
  logic                        init_load;
  logic [CNT_W-1:0]            init_count;
  logic                        mem_en;
  logic                        mem_we;
  logic [$clog2(MAP_ROWS)-1:0] mem_addr;
  logic [2*MAP_COLS-1:0]       mem_wdata;
  logic [2*MAP_COLS-1:0]       mem_rdata;
  logic                        busy;
  logic                        pellet_eaten;
  logic                        power_eaten;
  logic [CNT_W-1:0]            pellet_count;
  logic                        level_clear;

  modport master (
    input  pos_valid, pacman_curr_pos_x, pacman_curr_pos_y, init_load, init_count, mem_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, pellet_eaten, power_eaten,
           pellet_count, level_clear
  );

  modport slave (
    output pos_valid, pacman_curr_pos_x, pacman_curr_pos_y, init_load, init_count, mem_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, pellet_eaten, power_eaten,
           pellet_count, level_clear
  );
endinterface

// File: rtl/food_flush_ctrl.sv
// Clears the food_map tile under pacman with a 4-cycle read-modify-write of the RAM row,
// reports pellet/power-pellet eat events and tracks the remaining pellet count.
module food_flush_ctrl #(
  parameter int MAP_COLS        = 40,
  parameter int MAP_ROWS        = 30,
  parameter int TILE_SHIFT      = 4,
  parameter int H_VISIBLE_START = 0,
  parameter int V_VISIBLE_START = 0,
  parameter int MOVE_TO_CENTER  = 0,
  parameter int CNT_W           = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  food_flush_if.master     bus,
  output logic [2:0]       state_dbg
);
  localparam int ROW_W = $clog2(MAP_ROWS);
  localparam int COL_W = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1;
  localparam int RAM_W = 2 * MAP_COLS;
  localparam int IDX_W = $clog2(RAM_W);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_CHK, S_WR} state_t;

  state_t state, state_nx;

  logic             pend_vld;
  logic [10:0]      pend_x;
  logic [9:0]       pend_y;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [RAM_W-1:0] rdata_q;
  logic [1:0]       code_q;
  logic             last_vld;
  logic [ROW_W-1:0] last_row;
  logic [COL_W-1:0] last_col;
  logic             loaded_q;
  logic             clear_q;
  logic [CNT_W-1:0] count_q;

  logic [10:0]      req_x;
  logic [9:0]       req_y;
  logic             req_avail;
  logic [11:0]      x_off;
  logic [10:0]      y_off;
  logic [10:0]      col_full;
  logic [9:0]       row_full;
  logic             req_ok;
  logic             req_dup;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic             take;
  logic [IDX_W-1:0] bit_base;
  logic [1:0]       cur_code;
  logic             clearable;
  logic             tile_done;
  logic [RAM_W-1:0] clr_mask;
  logic [CNT_W-1:0] count_nx;
  logic             loaded_nx;

  // A waiting pending entry is always served before a fresh position.
  always_comb begin
    req_x     = bus.pacman_curr_pos_x;
    req_y     = bus.pacman_curr_pos_y;
    req_avail = 1'b0;
    if (state == S_IDLE) begin
      if (pend_vld) begin
        req_x     = pend_x;
        req_y     = pend_y;
        req_avail = 1'b1;
      end else begin
        req_avail = bus.pos_valid;
      end
    end
  end

  // One extra bit on the subtraction makes a position left of / above the map negative.
  always_comb begin
    x_off    = {1'b0, req_x} - 12'(H_VISIBLE_START + MOVE_TO_CENTER);
    y_off    = {1'b0, req_y} - 11'(V_VISIBLE_START + MOVE_TO_CENTER);
    col_full = x_off[10:0] >> TILE_SHIFT;
    row_full = y_off[9:0] >> TILE_SHIFT;
    req_ok   = !x_off[11] && !y_off[10] &&
               (col_full < 11'(MAP_COLS)) && (row_full < 10'(MAP_ROWS));
    req_row  = row_full[ROW_W-1:0];
    req_col  = col_full[COL_W-1:0];
    req_dup  = last_vld && (req_row == last_row) && (req_col == last_col);
    take     = req_avail && req_ok && !req_dup;
  end

  always_comb begin
    bit_base  = IDX_W'({col_q, 1'b0});
    cur_code  = bus.mem_rdata[bit_base +: 2];
    clearable = (cur_code == 2'b01) || (cur_code == 2'b10);
    tile_done = ((state == S_CHK) && !clearable) || (state == S_WR);
    clr_mask  = RAM_W'(2'b11) << bit_base;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (take) state_nx = S_RD;
      S_RD:    state_nx = S_WAIT;
      S_WAIT:  state_nx = S_CHK;
      S_CHK:   state_nx = clearable ? S_WR : S_IDLE;
      S_WR:    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // init_load wins over a decrement landing in the same cycle.
  always_comb begin
    count_nx  = count_q;
    loaded_nx = loaded_q | bus.init_load;
    if (bus.init_load)
      count_nx = bus.init_count;
    else if ((state == S_WR) && (count_q != '0))
      count_nx = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_x   <= '0;
      pend_y   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      rdata_q  <= '0;
      code_q   <= '0;
      last_vld <= 1'b0;
      last_row <= '0;
      last_col <= '0;
      loaded_q <= 1'b0;
      clear_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      if (take) begin
        row_q <= req_row;
        col_q <= req_col;
      end
      if (state == S_CHK) begin
        rdata_q <= bus.mem_rdata;
        code_q  <= cur_code;
      end
      if ((state != S_IDLE) || pend_vld) begin
        pend_vld <= bus.pos_valid || (pend_vld && (state != S_IDLE));
        if (bus.pos_valid) begin
          pend_x <= bus.pacman_curr_pos_x;
          pend_y <= bus.pacman_curr_pos_y;
        end
      end
      if (bus.init_load) begin
        last_vld <= 1'b0;
      end else if (tile_done) begin
        last_vld <= 1'b1;
        last_row <= row_q;
        last_col <= col_q;
      end
      count_q  <= count_nx;
      loaded_q <= loaded_nx;
      clear_q  <= (count_nx == '0) && loaded_nx;
    end
  end

  always_comb begin
    bus.mem_en       = (state == S_RD) || (state == S_WR);
    bus.mem_we       = (state == S_WR);
    bus.mem_addr     = bus.mem_en ? row_q : '0;
    bus.mem_wdata    = (state == S_WR) ? (rdata_q & ~clr_mask) : '0;
    bus.busy         = (state != S_IDLE);
    bus.pellet_eaten = (state == S_WR) && (code_q == 2'b01);
    bus.power_eaten  = (state == S_WR) && (code_q == 2'b10);
    bus.pellet_count = count_q;
    bus.level_clear  = clear_q;
    state_dbg        = state;
  end
endmodule

// File: tb/tb_food_flush_ctrl.sv
// Bench for food_flush_ctrl: RAM model, tile-map reference model with a per-cycle
// compare process, and directed scenarios with literal expectations.
module tb_food_flush_ctrl;
  localparam int MAP_COLS = 40;
  localparam int MAP_ROWS = 30;
  localparam int CNT_W    = 12;
  localparam int ROW_W    = $clog2(MAP_ROWS);
  localparam int RAM_W    = 2 * MAP_COLS;
  localparam int TILE     = 16;
  localparam int MAXC     = 512;

  typedef logic [RAM_W-1:0] w_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] state_dbg;

  food_flush_if #(.MAP_COLS(MAP_COLS), .MAP_ROWS(MAP_ROWS), .CNT_W(CNT_W)) bus ();

  food_flush_ctrl #(
    .MAP_COLS(MAP_COLS), .MAP_ROWS(MAP_ROWS), .TILE_SHIFT(4),
    .H_VISIBLE_START(0), .V_VISIBLE_START(0), .MOVE_TO_CENTER(0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, w_t act, w_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // food_map RAM with one cycle of read latency
  w_t ram [MAP_ROWS];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  // reference model: tile codes per (row, col), plus expected outputs scheduled by cycle
  logic [1:0]       m_map [MAP_ROWS][MAP_COLS];
  bit               e_en   [MAXC];
  bit               e_we   [MAXC];
  bit               e_busy [MAXC];
  bit               e_pel  [MAXC];
  bit               e_pow  [MAXC];
  bit [ROW_W-1:0]   e_addr [MAXC];
  bit [RAM_W-1:0]   e_wdata[MAXC];
  bit               chk_en = 0;
  int               m_free = 0;
  int               m_wr_cyc = -1;
  bit               m_pend = 0;
  int               m_px, m_py;
  bit               m_last_v = 0;
  int               m_last_r, m_last_c;
  logic [CNT_W-1:0] m_count = '0;
  bit               m_loaded = 0;
  bit               m_clear = 0;

  task automatic set_tile(input int r, input int c, input logic [1:0] code);
    w_t row_img;
    m_map[r][c] = code;
    row_img = '0;
    for (int j = MAP_COLS - 1; j >= 0; j--) row_img = (row_img << 2) | w_t'(m_map[r][j]);
    ram[r] = row_img;
  endtask

  // An accepted tile is read on c+1; a pellet/power tile is rewritten on c+4.
  task automatic model_accept(input int c, input int sx, input int sy);
    int col, row;
    logic [1:0] code;
    w_t img;
    if (sx < 0 || sy < 0) return;
    col = sx / TILE;
    row = sy / TILE;
    if (col >= MAP_COLS || row >= MAP_ROWS) return;
    if (m_last_v && m_last_r == row && m_last_c == col) return;
    code = m_map[row][col];
    for (int k = 1; k <= 3; k++) e_busy[c+k] = 1;
    e_en[c+1]   = 1;
    e_addr[c+1] = ROW_W'(row);
    m_last_v = 1;
    m_last_r = row;
    m_last_c = col;
    if (code == 2'b01 || code == 2'b10) begin
      m_map[row][col] = 2'b00;
      img = '0;
      for (int j = MAP_COLS - 1; j >= 0; j--) img = (img << 2) | w_t'(m_map[row][j]);
      e_busy[c+4]  = 1;
      e_en[c+4]    = 1;
      e_we[c+4]    = 1;
      e_addr[c+4]  = ROW_W'(row);
      e_wdata[c+4] = img;
      e_pel[c+4]   = (code == 2'b01);
      e_pow[c+4]   = (code == 2'b10);
      m_wr_cyc     = c + 4;
      m_free       = c + 5;
    end else begin
      m_free = c + 4;
    end
  endtask

  // scoreboard compare every cycle, then advance the model with this cycle's inputs
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_en", w_t'(bus.mem_en), w_t'(e_en[cyc]));
      chk("mem_we", w_t'(bus.mem_we), w_t'(e_we[cyc]));
      chk("busy", w_t'(bus.busy), w_t'(e_busy[cyc]));
      chk("pellet_eaten", w_t'(bus.pellet_eaten), w_t'(e_pel[cyc]));
      chk("power_eaten", w_t'(bus.power_eaten), w_t'(e_pow[cyc]));
      chk("pellet_count", w_t'(bus.pellet_count), w_t'(m_count));
      chk("level_clear", w_t'(bus.level_clear), w_t'(m_clear));
      if (e_en[cyc]) chk("mem_addr", w_t'(bus.mem_addr), w_t'(e_addr[cyc]));
      if (e_we[cyc]) chk("mem_wdata", bus.mem_wdata, e_wdata[cyc]);

      if (cyc >= m_free) begin
        if (m_pend) begin
          m_pend = bus.pos_valid;
          model_accept(cyc, m_px, m_py);
          if (bus.pos_valid) begin
            m_px = int'(bus.pacman_curr_pos_x);
            m_py = int'(bus.pacman_curr_pos_y);
          end
        end else if (bus.pos_valid) begin
          model_accept(cyc, int'(bus.pacman_curr_pos_x), int'(bus.pacman_curr_pos_y));
        end
      end else if (bus.pos_valid) begin
        m_pend = 1;
        m_px   = int'(bus.pacman_curr_pos_x);
        m_py   = int'(bus.pacman_curr_pos_y);
      end

      if (bus.init_load) begin
        m_count  = bus.init_count;
        m_loaded = 1;
        m_last_v = 0;
      end else if (m_wr_cyc == cyc && m_count != 0) begin
        m_count = m_count - 1'b1;
      end
      m_clear = (m_count == 0) && m_loaded;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pos(input int x, input int y);
    bus.pos_valid         = 1'b1;
    bus.pacman_curr_pos_x = 11'(x);
    bus.pacman_curr_pos_y = 10'(y);
    tick();
    bus.pos_valid = 1'b0;
  endtask

  task automatic load(input int n);
    bus.init_load  = 1'b1;
    bus.init_count = CNT_W'(n);
    tick();
    bus.init_load = 1'b0;
  endtask

  int rst_acc = 0;

  initial begin
    rst_n                 = 1'b0;
    bus.pos_valid         = 1'b0;
    bus.pacman_curr_pos_x = '0;
    bus.pacman_curr_pos_y = '0;
    bus.init_load         = 1'b0;
    bus.init_count        = '0;
    for (int r = 0; r < MAP_ROWS; r++)
      for (int c = 0; c < MAP_COLS; c++) set_tile(r, c, 2'b00);
    for (int c = 0; c < MAP_COLS; c++) set_tile(27, c, 2'b11);
    set_tile(27, 38, 2'b01);
    for (int c = 0; c < MAP_COLS; c++) set_tile(23, c, 2'b01);
    set_tile(23, 29, 2'b10);
    set_tile(5, 3, 2'b11);
    set_tile(10, 10, 2'b01);
    set_tile(10, 11, 2'b01);
    set_tile(10, 12, 2'b10);
    set_tile(12, 1, 2'b01);
    set_tile(14, 2, 2'b01);

    repeat (3) tick();
    chk("reset mem_en", w_t'(bus.mem_en), w_t'(0));
    chk("reset busy", w_t'(bus.busy), w_t'(0));
    chk("reset pellet_count", w_t'(bus.pellet_count), w_t'(0));
    chk("reset level_clear", w_t'(bus.level_clear), w_t'(0));
    chk("reset fsm idle", w_t'(state_dbg), w_t'(0));
    rst_n  = 1'b1;
    chk_en = 1;

    load(5);
    tick();
    chk("count after load", w_t'(bus.pellet_count), w_t'(5));

    // pellet at tile (27,38)
    drive_pos(38 * 16, 27 * 16);
    chk("rd en", w_t'(bus.mem_en), w_t'(1));
    chk("rd we", w_t'(bus.mem_we), w_t'(0));
    chk("rd addr", w_t'(bus.mem_addr), w_t'(27));
    repeat (3) tick();
    chk("wr we", w_t'(bus.mem_we), w_t'(1));
    chk("wr pellet pulse", w_t'(bus.pellet_eaten), w_t'(1));
    chk("wr data row27", bus.mem_wdata, 80'hCFFFFFFFFFFFFFFFFFFF);
    tick();
    chk("count after pellet", w_t'(bus.pellet_count), w_t'(4));

    // same tile again, different pixel inside it
    drive_pos(38 * 16 + 5, 27 * 16 + 9);
    repeat (5) tick();
    chk("count after duplicate", w_t'(bus.pellet_count), w_t'(4));

    // power pellet at tile (23,29)
    drive_pos(29 * 16, 23 * 16);
    repeat (6) tick();
    chk("count after power", w_t'(bus.pellet_count), w_t'(3));

    // wall then empty tile
    drive_pos(3 * 16, 5 * 16);
    repeat (6) tick();
    drive_pos(4 * 16 + 15, 5 * 16 + 3);
    repeat (6) tick();
    chk("count after wall/empty", w_t'(bus.pellet_count), w_t'(3));

    // column 40 is off the map
    drive_pos(40 * 16, 0);
    chk("oob busy", w_t'(bus.busy), w_t'(0));
    chk("oob mem_en", w_t'(bus.mem_en), w_t'(0));
    repeat (4) tick();

    // A, B, C back to back: B is overwritten by C in the pending slot
    bus.pos_valid         = 1'b1;
    bus.pacman_curr_pos_y = 10'(10 * 16);
    bus.pacman_curr_pos_x = 11'(10 * 16);
    tick();
    bus.pacman_curr_pos_x = 11'(11 * 16);
    tick();
    bus.pacman_curr_pos_x = 11'(12 * 16);
    tick();
    bus.pos_valid = 1'b0;
    repeat (3) tick();
    chk("pending rd en", w_t'(bus.mem_en), w_t'(1));
    chk("pending rd addr", w_t'(bus.mem_addr), w_t'(10));
    repeat (3) tick();
    chk("pending power pulse", w_t'(bus.power_eaten), w_t'(1));
    chk("pending wr data", bus.mem_wdata, 80'h400000);
    repeat (3) tick();
    chk("count after A,C", w_t'(bus.pellet_count), w_t'(1));

    // last pellet of the level
    load(1);
    tick();
    chk("clear before eat", w_t'(bus.level_clear), w_t'(0));
    drive_pos(1 * 16, 12 * 16);
    repeat (3) tick();
    chk("clear in wr cycle", w_t'(bus.level_clear), w_t'(0));
    chk("last pellet pulse", w_t'(bus.pellet_eaten), w_t'(1));
    tick();
    chk("clear after wr", w_t'(bus.level_clear), w_t'(1));
    chk("count zero", w_t'(bus.pellet_count), w_t'(0));

    // reset during the WAIT cycle of a further RMW
    drive_pos(2 * 16, 14 * 16);
    tick();
    chk_en = 0;
    rst_n  = 1'b0;
    #1;
    chk("abort mem_en", w_t'(bus.mem_en), w_t'(0));
    chk("abort mem_we", w_t'(bus.mem_we), w_t'(0));
    chk("abort busy", w_t'(bus.busy), w_t'(0));
    chk("abort level_clear", w_t'(bus.level_clear), w_t'(0));
    chk("abort pellet_count", w_t'(bus.pellet_count), w_t'(0));
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_en || bus.mem_we) rst_acc++;
    end
    chk("no access in reset", w_t'(rst_acc), w_t'(0));
    chk("row14 intact", ram[14], 80'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
